// File: rtl/mmio_irq_ctrl_pkg.sv
// mmio_pkg: shared types and STATUS/CTRL bit positions for the MMIO interrupt controller
package mmio_pkg;
  typedef enum logic [1:0] {IDLE, PEND, SERV} irq_state_t;
  typedef enum logic [1:0] {SEL_NONE, SEL_RAM, SEL_DATA, SEL_STAT} rd_sel_t;
  localparam int STAT_IEN = 0;
  localparam int STAT_CLR = 1;
  localparam int STAT_BUSY = 1;
  localparam int STAT_MISSED = 2;
endpackage

// File: rtl/mmio_irq_ctrl_input_sync_edge.sv
// input_sync_edge: two-flop synchroniser with a delayed copy to flag any change of the synced input
module input_sync_edge #(
  parameter int NBITS = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NBITS-1:0] din,
  output logic [NBITS-1:0] sync,
  output logic             change
);
  logic [NBITS-1:0] sync1, prev;
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync  <= '0;
      prev  <= '0;
    end else begin
      sync1 <= din;
      sync  <= sync1;
      prev  <= sync;
    end
  end
  assign change = sync != prev;
endmodule

// File: rtl/mmio_irq_ctrl.sv
// mmio_irq_ctrl: address decode, saida register, aligned load mux and change-interrupt FSM
module mmio_irq_ctrl
  import mmio_pkg::*;
#(
  parameter int NBITS = 8,
  parameter logic [NBITS-3:0] DATA_ADDR = '1,
  parameter logic [NBITS-3:0] STAT_ADDR = {{(NBITS-3){1'b1}}, 1'b0}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NBITS-3:0] memAddress,
  input  logic [NBITS-1:0] memWriteData,
  input  logic             memMemWrite,
  input  logic             isLoad,
  input  logic [NBITS-1:0] ramReadData,
  output logic             ramWrEn,
  output logic [NBITS-1:0] memReadData,
  input  logic [NBITS-1:0] entrada,
  output logic [NBITS-1:0] saida,
  output logic             interrupt,
  input  logic             irq_ack
);
  logic is_data, is_stat, clear, change, ien, missed, missed_nxt, irq_nxt;
  logic [NBITS-1:0] sync_val, stat_val, rd_io_val;
  irq_state_t state, state_nxt;
  rd_sel_t rd_sel, sel_nxt;

  input_sync_edge #(.NBITS(NBITS)) u_sync (
    .clock (clock),
    .reset (reset),
    .din   (entrada),
    .sync  (sync_val),
    .change(change)
  );

  assign is_data = memAddress == DATA_ADDR;
  assign is_stat = memAddress == STAT_ADDR;
  assign ramWrEn = memMemWrite & ~(is_data | is_stat);
  assign clear   = memMemWrite & is_stat & memWriteData[STAT_CLR];
  assign sel_nxt = !isLoad ? SEL_NONE : is_data ? SEL_DATA : is_stat ? SEL_STAT : SEL_RAM;
  assign memReadData = (rd_sel == SEL_DATA || rd_sel == SEL_STAT) ? rd_io_val :
                       rd_sel == SEL_RAM ? ramReadData : '0;

  always_comb begin
    stat_val = '0;
    stat_val[STAT_IEN] = ien;
    stat_val[STAT_BUSY] = state != IDLE;
    stat_val[STAT_MISSED] = missed;
  end

  // disabling interrupts abandons any pending or in-service request
  always_comb begin
    state_nxt = state;
    irq_nxt = interrupt;
    missed_nxt = missed;
    if (!ien) begin
      state_nxt = IDLE;
      irq_nxt = 1'b0;
      missed_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: if (change) begin
          state_nxt = PEND;
          irq_nxt = 1'b1;
        end
        PEND: if (irq_ack) begin
          state_nxt = SERV;
          irq_nxt = 1'b0;
        end
        SERV: if (clear) begin
          state_nxt = (missed | change) ? PEND : IDLE;
          irq_nxt = missed | change;
          missed_nxt = 1'b0;
        end else if (change) missed_nxt = 1'b1;
        default: begin
          state_nxt = IDLE;
          irq_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      interrupt <= 1'b0;
      missed    <= 1'b0;
      ien       <= 1'b0;
      saida     <= '0;
      rd_sel    <= SEL_NONE;
      rd_io_val <= '0;
    end else begin
      state     <= state_nxt;
      interrupt <= irq_nxt;
      missed    <= missed_nxt;
      rd_sel    <= sel_nxt;
      rd_io_val <= is_data ? sync_val : stat_val;
      if (memMemWrite & is_data) saida <= memWriteData;
      if (memMemWrite & is_stat) ien <= memWriteData[STAT_IEN];
    end
  end
endmodule

// File: tb/tb_mmio_irq_ctrl.sv
// tb_mmio_irq_ctrl: scoreboard bench with a history-based reference model and a behavioural memo
module tb_mmio_irq_ctrl;
  localparam logic [5:0] DA = 6'h3F;
  localparam logic [5:0] SA = 6'h3E;
  logic clock = 1'b0;
  logic reset, memMemWrite, isLoad, irq_ack, ramWrEn, interrupt;
  logic [5:0] memAddress;
  logic [7:0] memWriteData, ramReadData, memReadData, entrada, saida;
  bit done = 1'b0;

  mmio_irq_ctrl #(.NBITS(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .memAddress  (memAddress),
    .memWriteData(memWriteData),
    .memMemWrite (memMemWrite),
    .isLoad      (isLoad),
    .ramReadData (ramReadData),
    .ramWrEn     (ramWrEn),
    .memReadData (memReadData),
    .entrada     (entrada),
    .saida       (saida),
    .interrupt   (interrupt),
    .irq_ack     (irq_ack)
  );

  always #5 clock = ~clock;

  logic [7:0] ram [0:63];
  always @(posedge clock) begin
    if (memMemWrite && memAddress != DA && memAddress != SA) ram[memAddress] <= memWriteData;
    ramReadData <= ram[memAddress];
  end

  typedef struct {
    int cyc;
    int kind;
    logic [7:0] v;
  } exp_t;
  exp_t sbq[$];
  int cyc = 0;
  int checks = 0;
  int fails = 0;

  logic [7:0] eh [0:8191];
  logic [7:0] cur_e = 8'h00;
  bit m_ien, m_missed, m_saw_clear;
  int m_st;
  logic [7:0] m_saida;

  function automatic logic [7:0] hist(int i);
    return i < 0 ? 8'h00 : eh[i];
  endfunction

  function automatic void push(int c, int k, logic [7:0] v);
    exp_t e;
    e.cyc = c;
    e.kind = k;
    e.v = v;
    sbq.push_back(e);
  endfunction

  function automatic string kname(int k);
    return k == 0 ? "ramWrEn" : k == 1 ? "interrupt" : k == 2 ? "saida" : "memReadData";
  endfunction

  exp_t me;
  logic [7:0] act;
  always @(negedge clock) begin
    while (sbq.size() > 0 && sbq[0].cyc == cyc) begin
      me = sbq.pop_front();
      act = me.kind == 0 ? {7'b0, ramWrEn} : me.kind == 1 ? {7'b0, interrupt} :
            me.kind == 2 ? saida : memReadData;
      checks++;
      if (act !== me.v) begin
        fails++;
        $display("FAIL %s cyc=%0d got=%h expected=%h", kname(me.kind), cyc, act, me.v);
      end
    end
  end

  initial begin
    #2000000;
    if (!done) begin
      fails++;
      $display("FAIL timeout: stimulus did not finish");
      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
    end
  end

  task automatic check_reset();
    checks++;
    if (interrupt !== 1'b0 || saida !== 8'h00 || ramWrEn !== 1'b0) begin
      fails++;
      $display("FAIL reset state cyc=%0d interrupt=%b saida=%h ramWrEn=%b", cyc, interrupt, saida, ramWrEn);
    end
  endtask

  task automatic step(input bit rst, input bit wr, input bit ld, input bit ack,
                      input logic [5:0] a, input logic [7:0] d, input logic [7:0] e);
    bit chg, clr, io;
    logic [7:0] s2, rv;
    reset = rst;
    memMemWrite = wr;
    isLoad = ld;
    irq_ack = ack;
    memAddress = a;
    memWriteData = d;
    entrada = e;
    cur_e = e;
    eh[cyc] = rst ? 8'h00 : e;
    io = a == DA || a == SA;
    push(cyc, 0, {7'b0, wr && !io});
    if (rst) begin
      m_ien = 0;
      m_missed = 0;
      m_st = 0;
      m_saida = 0;
      rv = 0;
    end else begin
      s2 = hist(cyc - 2);
      chg = s2 != hist(cyc - 3);
      clr = wr && a == SA && d[1];
      rv = !ld ? 8'h00 : a == DA ? s2 : a == SA ? {5'b0, m_missed, m_st != 0, m_ien} : ram[a];
      if (!m_ien) begin
        m_st = 0;
        m_missed = 0;
      end else if (m_st == 0 && chg) m_st = 1;
      else if (m_st == 1 && ack) m_st = 2;
      else if (m_st == 2 && clr) begin
        m_st = (m_missed || chg) ? 1 : 0;
        m_missed = 0;
      end else if (m_st == 2 && chg) m_missed = 1;
      if (wr && a == SA) m_ien = d[0];
      if (wr && a == DA) m_saida = d;
    end
    push(cyc + 1, 1, {7'b0, m_st == 1});
    push(cyc + 1, 2, m_saida);
    push(cyc + 1, 3, rv);
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 6'd0, 8'h00, cur_e);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 6'd0, 8'h00, cur_e);
  endtask

  initial begin
    reset = 1'b1;
    memMemWrite = 1'b0;
    isLoad = 1'b0;
    irq_ack = 1'b0;
    memAddress = '0;
    memWriteData = '0;
    entrada = '0;
    @(posedge clock);
    #1;
    do_reset();
    check_reset();
    step(0, 1, 0, 0, DA, 8'hA5, cur_e);
    idle(1);
    step(0, 1, 0, 0, 6'd5, 8'h3C, cur_e);
    step(0, 0, 1, 0, 6'd5, 8'h00, cur_e);
    idle(1);
    step(0, 1, 0, 0, SA, 8'h01, cur_e);
    step(0, 0, 0, 0, 6'd0, 8'h00, 8'h01);
    idle(5);
    step(0, 0, 0, 1, 6'd0, 8'h00, cur_e);
    idle(1);
    step(0, 0, 0, 0, 6'd0, 8'h00, 8'h00);
    idle(4);
    step(0, 0, 1, 0, SA, 8'h00, cur_e);
    step(0, 1, 0, 0, SA, 8'h03, cur_e);
    idle(2);
    step(0, 1, 0, 0, SA, 8'h00, cur_e);
    step(0, 0, 0, 0, 6'd0, 8'h00, 8'h12);
    step(0, 0, 0, 0, 6'd0, 8'h00, 8'h34);
    step(0, 0, 0, 0, 6'd0, 8'h00, 8'h56);
    idle(1);
    step(0, 0, 1, 0, DA, 8'h00, cur_e);
    idle(4);
    step(0, 1, 0, 0, SA, 8'h01, cur_e);
    step(0, 0, 0, 0, 6'd0, 8'h00, 8'h99);
    idle(5);
    do_reset();
    check_reset();
    step(0, 0, 1, 0, SA, 8'h00, cur_e);
    idle(3);
    for (int n = 0; n < 2000; n++) begin
      int r, s;
      logic [5:0] a;
      logic [7:0] d;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        check_reset();
        continue;
      end
      s = $urandom_range(0, 3);
      a = s == 0 ? DA : s == 1 ? SA : 6'($urandom_range(0, 61));
      d = 8'($urandom);
      if (a == SA) d[0] = $urandom_range(0, 7) != 0;
      if ($urandom_range(0, 5) == 0) cur_e = 8'($urandom);
      r = $urandom_range(0, 9);
      step(0, r >= 3 && r < 5, r >= 5 && r < 8, $urandom_range(0, 3) == 0, a, d, cur_e);
    end
    idle(3);
    done = 1'b1;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
